// File: rtl/glyph_blitter_pkg.sv
// Shared types and default geometry for the glyph blitter.
// Optional bounds checking is enabled with BOUNDS_CHECK_EN.
package glyph_blitter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        WRITE,
        DONE
    } state_e;

    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;
    localparam int DEF_CHAR_W   = 20;
    localparam int DEF_CHAR_H   = 30;
    localparam int DEF_Y_ORIGIN = 270;
    localparam int DEF_ADDR_W   = 19;
    localparam int DEF_COLOR_W  = 3;
    localparam int DEF_GLYPH_AW = 13;

    localparam int DEF_ROW_STEP = DEF_SCREEN_W - (DEF_CHAR_W - 1);
    localparam int DEF_MAX_COLS = DEF_SCREEN_W / DEF_CHAR_W;
    localparam int DEF_MAX_ROWS = (DEF_SCREEN_H - DEF_Y_ORIGIN) / DEF_CHAR_H;

    // Width of a counter that must reach n-1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/glyph_row_shifter.sv
// Holds one glyph row and presents one pixel bit per WRITE cycle.
// Flags the last pixel so the FSM can advance to the next row.
module glyph_row_shifter
    import glyph_blitter_pkg::*;
#(
    parameter int CHAR_W = DEF_CHAR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [CHAR_W-1:0] din,
    output logic              bit_o,
    output logic              last_o
);

    localparam int PW = cnt_w(CHAR_W);
    localparam logic [PW-1:0] LAST_PX = PW'(CHAR_W - 1);

    logic [CHAR_W-1:0] sr_q, sr_d;
    logic [PW-1:0]     px_q, px_d;

    // Load a fresh row, or shift toward bit 0 one pixel per cycle.
    always_comb begin
        sr_d = sr_q;
        px_d = px_q;
        if (load) begin
            sr_d = din;
            px_d = '0;
        end else if (shift) begin
            sr_d = sr_q >> 1;
            px_d = px_q + PW'(1);
        end
    end

    // Row register and pixel counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            sr_q <= '0;
            px_q <= '0;
        end else begin
            sr_q <= sr_d;
            px_q <= px_d;
        end
    end

    assign bit_o  = sr_q[0];
    assign last_o = (px_q == LAST_PX);

endmodule

// File: rtl/glyph_blitter.sv
// Writes one glyph into the framebuffer, one pixel per cycle.
// Define BOUNDS_CHECK_EN to reject cells outside the text region.
module glyph_blitter
    import glyph_blitter_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int CHAR_W   = DEF_CHAR_W,
    parameter int CHAR_H   = DEF_CHAR_H,
    parameter int Y_ORIGIN = DEF_Y_ORIGIN,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int COLOR_W  = DEF_COLOR_W,
    parameter int GLYPH_AW = DEF_GLYPH_AW
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [7:0]          req_row,
    input  logic [7:0]          req_col,
    input  logic [7:0]          req_char,
    input  logic [COLOR_W-1:0]  req_fg,
    input  logic [COLOR_W-1:0]  req_bg,
    input  logic                req_transparent,
    output logic [GLYPH_AW-1:0] glyph_addr,
    input  logic [CHAR_W-1:0]   glyph_data,
    output logic [ADDR_W-1:0]   mem_waddr,
    output logic [COLOR_W-1:0]  mem_wdata,
    output logic                mem_wenable,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int ROW_STEP = SCREEN_W - (CHAR_W - 1);
    localparam int RW = cnt_w(CHAR_H);
    localparam logic [RW-1:0] LAST_ROW = RW'(CHAR_H - 1);

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [GLYPH_AW-1:0]  gaddr_q, gaddr_d;
    logic [RW-1:0]        grow_q, grow_d;
    logic [COLOR_W-1:0]   fg_q, fg_d;
    logic [COLOR_W-1:0]   bg_q, bg_d;
    logic                 transp_q, transp_d;
    logic                 err_q, err_d;

    logic                 oob;
    logic                 sh_load;
    logic                 sh_shift;
    logic                 sh_bit;
    logic                 sh_last;
    logic [ADDR_W-1:0]    base;
    logic [GLYPH_AW-1:0]  gbase;

    // Top-left pixel of the cell; the one multiply, used at accept only.
    assign base = (ADDR_W'(Y_ORIGIN) + ADDR_W'(req_row) * ADDR_W'(CHAR_H))
                  * ADDR_W'(SCREEN_W)
                  + ADDR_W'(req_col) * ADDR_W'(CHAR_W);

    // First ROM row of the glyph; later rows just increment.
    assign gbase = GLYPH_AW'(req_char) * GLYPH_AW'(CHAR_H);

`ifdef BOUNDS_CHECK_EN
    // Cell must lie fully inside the visible text region.
    assign oob = (Y_ORIGIN + (int'(req_row) + 1) * CHAR_H > SCREEN_H)
              || ((int'(req_col) + 1) * CHAR_W > SCREEN_W);
`else
    assign oob = 1'b0;
`endif

    glyph_row_shifter #(
        .CHAR_W(CHAR_W)
    ) u_shifter (
        .clock (clock),
        .reset (reset),
        .load  (sh_load),
        .shift (sh_shift),
        .din   (glyph_data),
        .bit_o (sh_bit),
        .last_o(sh_last)
    );

    // Next-state, request latching and incremental address walk.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        gaddr_d  = gaddr_q;
        grow_d   = grow_q;
        fg_d     = fg_q;
        bg_d     = bg_q;
        transp_d = transp_q;
        err_d    = 1'b0;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (oob) begin
                        err_d = 1'b1;
                    end else begin
                        state_d  = FETCH;
                        addr_d   = base;
                        gaddr_d  = gbase;
                        grow_d   = '0;
                        fg_d     = req_fg;
                        bg_d     = req_bg;
                        transp_d = req_transparent;
                    end
                end
            end
            FETCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                sh_load = 1'b1;
                state_d = WRITE;
            end
            WRITE: begin
                sh_shift = 1'b1;
                if (sh_last) begin
                    addr_d = addr_q + ADDR_W'(ROW_STEP);
                    if (grow_q == LAST_ROW) begin
                        state_d = DONE;
                    end else begin
                        grow_d  = grow_q + RW'(1);
                        gaddr_d = gaddr_q + GLYPH_AW'(1);
                        state_d = FETCH;
                    end
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any character.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            gaddr_q  <= '0;
            grow_q   <= '0;
            fg_q     <= '0;
            bg_q     <= '0;
            transp_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            gaddr_q  <= gaddr_d;
            grow_q   <= grow_d;
            fg_q     <= fg_d;
            bg_q     <= bg_d;
            transp_q <= transp_d;
            err_q    <= err_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign err         = err_q;
    assign glyph_addr  = gaddr_q;
    assign mem_waddr   = addr_q;
    assign mem_wenable = (state_q == WRITE) && (sh_bit || !transp_q);
    assign mem_wdata   = (state_q != WRITE) ? '0 :
                         (sh_bit ? fg_q : bg_q);

endmodule

// File: tb/tb_glyph_blitter.sv
// Randomised self-checking bench for glyph_blitter.
// Expected per-cycle traces come from a cell-level model of the rules.
module tb_glyph_blitter;

    localparam int SW  = 640;
    localparam int SH  = 480;
    localparam int CW  = 20;
    localparam int CH  = 30;
    localparam int YO  = 270;
    localparam int AW  = 19;
    localparam int CLW = 3;
    localparam int GAW = 13;

    typedef struct {
        int busy;
        int wen;
        int done;
        int err;
        int chk_ga;
        int ga;
        int addr;
        int data;
    } rec_t;

    logic           clock = 1'b0;
    logic           reset;
    logic           req_valid;
    logic           req_ready;
    logic [7:0]     req_row;
    logic [7:0]     req_col;
    logic [7:0]     req_char;
    logic [CLW-1:0] req_fg;
    logic [CLW-1:0] req_bg;
    logic           req_transparent;
    logic [GAW-1:0] glyph_addr;
    logic [CW-1:0]  glyph_data;
    logic [AW-1:0]  mem_waddr;
    logic [CLW-1:0] mem_wdata;
    logic           mem_wenable;
    logic           busy;
    logic           done;
    logic           err;

    logic [CW-1:0]  rom [0:(1<<GAW)-1];

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   acc_n = 0;
    int   acc_cyc = 0;
    int   m_err = 0;
    rec_t q[$];
    rec_t cur;

    int   prev_busy = 0;
    int   p_busy = 0, p_wen = 0, p_done = 0;
    int   p_first_wen = 0, p_first_addr = 0;
    int   p_last_addr = 0, p_wr20 = 0, p_ga0 = 0;
    int   tot_wen = 0, tot_err = 0, done_cyc = 0;

    always #5 clock = ~clock;

    glyph_blitter dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_row        (req_row),
        .req_col        (req_col),
        .req_char       (req_char),
        .req_fg         (req_fg),
        .req_bg         (req_bg),
        .req_transparent(req_transparent),
        .glyph_addr     (glyph_addr),
        .glyph_data     (glyph_data),
        .mem_waddr      (mem_waddr),
        .mem_wdata      (mem_wdata),
        .mem_wenable    (mem_wenable),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    // Synchronous glyph ROM: data one cycle after address.
    always @(posedge clock) glyph_data <= rom[glyph_addr];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic rec_t idle_rec();
        rec_t r;
        r.busy = 0; r.wen = 0; r.done = 0; r.err = 0;
        r.chk_ga = 0; r.ga = 0; r.addr = 0; r.data = 0;
        return r;
    endfunction

    // Expand one accepted request into its cycle-by-cycle trace.
    task automatic model_accept();
        int            base;
        int            ga;
        logic [CW-1:0] bits;
        rec_t          r;
        acc_n++;
        acc_cyc = cyc;
`ifdef BOUNDS_CHECK_EN
        if (YO + (int'(req_row) + 1) * CH > SH ||
            (int'(req_col) + 1) * CW > SW) begin
            m_err = 1;
            return;
        end
`endif
        base = (YO + int'(req_row) * CH) * SW + int'(req_col) * CW;
        for (int gr = 0; gr < CH; gr++) begin
            ga = int'(req_char) * CH + gr;
            bits = rom[ga];
            r = idle_rec(); r.busy = 1; r.chk_ga = 1; r.ga = ga;
            q.push_back(r);
            r = idle_rec(); r.busy = 1;
            q.push_back(r);
            for (int p = 0; p < CW; p++) begin
                r = idle_rec();
                r.busy = 1;
                r.wen  = (bits[p] || !req_transparent) ? 1 : 0;
                r.addr = (base + gr * SW + p) % (1 << AW);
                r.data = bits[p] ? int'(req_fg) : int'(req_bg);
                q.push_back(r);
            end
        end
        r = idle_rec(); r.busy = 1; r.done = 1;
        q.push_back(r);
    endtask

    // Model: advance one cycle per rising edge.
    initial begin
        cur = idle_rec();
        forever begin
            @(posedge clock);
            if (reset) begin
                q.delete();
                cur = idle_rec();
            end else begin
                m_err = 0;
                if (cur.busy == 0 && req_valid) model_accept();
                if (q.size() > 0) cur = q.pop_front();
                else cur = idle_rec();
                cur.err = m_err;
            end
            cyc++;
        end
    end

    // Compare DUT with model every cycle; gather per-character stats.
    initial begin
        forever begin
            @(negedge clock);
            chk("busy", busy, cur.busy);
            chk("ready", req_ready, (cur.busy == 0) ? 1 : 0);
            chk("wen", mem_wenable, cur.wen);
            chk("done", done, cur.done);
            chk("err", err, cur.err);
            if (cur.wen != 0) begin
                chk("waddr", mem_waddr, cur.addr);
                chk("wdata", mem_wdata, cur.data);
            end
            if (cur.chk_ga != 0) chk("gaddr", glyph_addr, cur.ga);
            if (busy && prev_busy == 0) begin
                p_busy = 0; p_wen = 0; p_done = 0;
                p_first_wen = -1; p_first_addr = -1;
                p_last_addr = -1; p_wr20 = -1; p_ga0 = -1;
            end
            if (busy) begin
                if (p_busy == 0) p_ga0 = int'(glyph_addr);
                if (mem_wenable) begin
                    if (p_wen == 0) begin
                        p_first_addr = int'(mem_waddr);
                        p_first_wen = p_busy;
                    end
                    if (p_wen == 20) p_wr20 = int'(mem_waddr);
                    p_last_addr = int'(mem_waddr);
                    p_wen++;
                end
                p_busy++;
            end
            if (mem_wenable) tot_wen++;
            if (done) begin
                p_done++;
                done_cyc = cyc;
            end
            if (err) tot_err++;
            prev_busy = busy ? 1 : 0;
        end
    end

    task automatic send(input int r, input int c, input int ch,
                        input int fg, input int bg, input int tr);
        int n0;
        @(negedge clock);
        req_row = 8'(r); req_col = 8'(c); req_char = 8'(ch);
        req_fg = CLW'(fg); req_bg = CLW'(bg);
        req_transparent = tr[0];
        req_valid = 1'b1;
        n0 = acc_n;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            if (acc_n != n0) begin
                req_valid = 1'b0;
                return;
            end
        end
        req_valid = 1'b0;
        n_chk++; n_fail++;
        $display("FAIL accept_timeout: got none required 1");
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            if (cur.busy == 0 && q.size() == 0) begin
                @(negedge clock);
                return;
            end
        end
        n_chk++; n_fail++;
        $display("FAIL idle_timeout: got busy required idle");
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, w0, e0, d_a;
        for (int i = 0; i < (1 << GAW); i++) rom[i] = CW'($urandom);
        for (int i = 0; i < CH; i++) rom[32 * CH + i] = '0;
        reset = 1'b1; req_valid = 1'b0;
        req_row = '0; req_col = '0; req_char = '0;
        req_fg = '0; req_bg = '0; req_transparent = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_ready", req_ready, 1);
        chk("rst_waddr", mem_waddr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_gaddr", glyph_addr, 0);
        reset = 1'b0;

        send(0, 0, 8'h41, 7, 0, 0);
        wait_idle();
        chk("t1_first_addr", p_first_addr, 172800);
        chk("t1_last_addr", p_last_addr, 191379);
        chk("t1_writes", p_wen, 600);
        chk("t1_busy", p_busy, 661);
        chk("t1_first_wen_ofs", p_first_wen, 2);
        chk("t1_done", p_done, 1);

        send(1, 2, 8'h41, 3, 4, 0);
        wait_idle();
        chk("t2_first_addr", p_first_addr, 192040);
        chk("t2_row1_addr", p_wr20, 192680);
        chk("t2_gaddr0", p_ga0, 1950);

        send(2, 3, 8'h20, 5, 2, 1);
        wait_idle();
        chk("t3_writes", p_wen, 0);
        chk("t3_busy", p_busy, 661);
        chk("t3_done", p_done, 1);

        @(negedge clock);
        req_row = 8'd0; req_col = 8'd4; req_char = 8'h33;
        req_fg = 3'd6; req_bg = 3'd1; req_transparent = 1'b0;
        req_valid = 1'b1;
        n0 = acc_n;
        for (int i = 0; i < 2000 && acc_n == n0; i++) @(negedge clock);
        req_row = 8'd5; req_col = 8'd9; req_char = 8'h5a;
        req_fg = 3'd2; req_bg = 3'd5; req_transparent = 1'b1;
        n0 = acc_n;
        for (int i = 0; i < 2000 && acc_n == n0; i++) @(negedge clock);
        req_valid = 1'b0;
        d_a = acc_cyc - done_cyc;
        chk("b2b_gap", d_a, 1);
        wait_idle();

        send(3, 5, 8'h7e, 1, 6, 0);
        for (int i = 0; i < 2000 && p_busy < 100; i++) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        w0 = tot_wen;
        repeat (5) @(negedge clock);
        chk("rst_abort_done", p_done, 0);
        chk("rst_abort_wen", tot_wen - w0, 0);

        send(6, 31, 8'h12, 7, 3, 0);
        wait_idle();
        chk("t6_last_addr", p_last_addr, 307199);

        e0 = tot_err; w0 = tot_wen;
        send(7, 0, 8'h41, 7, 0, 0);
`ifdef BOUNDS_CHECK_EN
        repeat (3) @(negedge clock);
        chk("oob_err", tot_err - e0, 1);
        chk("oob_wen", tot_wen - w0, 0);
`else
        wait_idle();
        chk("noerr", tot_err - e0, 0);
`endif
        send(255, 255, $urandom_range(0, 255), 7, 1, 0);
        wait_idle();

        for (int k = 0; k < 6; k++) begin
            send($urandom_range(0, 6), $urandom_range(0, 31),
                 $urandom_range(0, 255), $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 1));
            wait_idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/glyph_blitter.md
Name: glyph_blitter

Overview:
- Parametrised character-to-framebuffer writer for the text region of the VGA display.
- Accepts one character request (cell row, cell column, glyph code, colours) over a valid/ready handshake.
- Fetches the glyph row by row from an external row-organised glyph ROM and streams one pixel write per cycle into the framebuffer write port.
- Adds configurable glyph and screen geometry, colour depth, fg/bg colours, transparent mode and a done pulse.

Parameters:
SCREEN_W, 640, framebuffer width in pixels
SCREEN_H, 480, framebuffer height in pixels
CHAR_W, 20, glyph width in pixels
CHAR_H, 30, glyph height in pixels
Y_ORIGIN, 270, first pixel line of the text region
ADDR_W, 19, framebuffer address width
COLOR_W, 3, bits per pixel
GLYPH_AW, 13, glyph ROM address width (must hold 256*CHAR_H)

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_row  in  8  text cell row
req_col  in  8  text cell column
req_char  in  8  glyph code
req_fg  in  COLOR_W  colour for set glyph bits
req_bg  in  COLOR_W  colour for clear glyph bits
req_transparent  in  1  1 = skip clear bits (no write)
glyph_addr  out  GLYPH_AW  ROM row address = char*CHAR_H + glyph_row
glyph_data  in  CHAR_W  ROM row data, bit 0 = leftmost pixel, valid 1 cycle after glyph_addr
mem_waddr  out  ADDR_W  framebuffer write address
mem_wdata  out  COLOR_W  framebuffer write data
mem_wenable  out  1  framebuffer write strobe
busy  out  1  request in progress
done  out  1  one-cycle pulse when a character completes
err  out  1  one-cycle pulse on rejected request (BOUNDS_CHECK_EN only)

Behaviour:
- Reset: state IDLE; req_ready=1; busy, done, err, mem_wenable = 0; mem_waddr, mem_wdata, glyph_addr = 0. Reset mid-character aborts immediately; no further writes, no done.
- Handshake: a request is accepted on a rising edge with req_valid & req_ready. All req_* fields are latched on that edge.
- req_ready = (state==IDLE); it never depends combinationally on req_valid.
- States:
  - IDLE: on accept, compute base = (Y_ORIGIN + row*CHAR_H)*SCREEN_W + col*CHAR_W (only multiply in the design, evaluated once). Set glyph_row=0, go to FETCH.
  - FETCH (1 cycle): drive glyph_addr = char*CHAR_H + glyph_row; go to WAIT.
  - WAIT (1 cycle): register glyph_data into row shift register; px=0; go to WRITE.
  - WRITE (CHAR_W cycles): each cycle mem_waddr = base + glyph_row*SCREEN_W + px, maintained incrementally (+1 per pixel, + SCREEN_W-(CHAR_W-1) at row end, no multiply).
    - Bit set: wdata = fg, wenable = 1.
    - Bit clear: wdata = bg, wenable = !transparent.
    - After px = CHAR_W-1: if glyph_row = CHAR_H-1 go to DONE, else glyph_row+1 and go to FETCH.
  - DONE (1 cycle): done = 1; return to IDLE.
- busy = (state != IDLE).
- Latency: total busy cycles = CHAR_H*(CHAR_W+2)+1 (661 at defaults). First write occurs 2 cycles after acceptance.
- Width rules: address arithmetic is ADDR_W bits, unsigned. Without bounds check, out-of-range addresses wrap modulo 2^ADDR_W.
- mem_wenable is 0 in IDLE, FETCH, WAIT and DONE.
- req_valid held high while busy is ignored until req_ready returns. A back-to-back request is accepted in the cycle after DONE.

Optional Feature:
BOUNDS_CHECK_EN
- Defined: at acceptance, if Y_ORIGIN + (row+1)*CHAR_H > SCREEN_H or (col+1)*CHAR_W > SCREEN_W, then:
  - err pulses 1 cycle;
  - state stays IDLE with no writes and no done;
  - req_ready remains 1.
- Undefined: err is tied 0 and no check is made.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, FETCH, WAIT, WRITE, DONE);
  - default geometry constants;
  - derived constants ROW_STEP = SCREEN_W-(CHAR_W-1) and MAX_COLS/MAX_ROWS.
- One natural sub-module: glyph_row_shifter (loads CHAR_W bits, shifts out one bit per pixel, flags last pixel).
- Glyph ROM stays external.

Test Plan:
- Reset then req row=0 col=0 char=0x41 fg=7 bg=0 transparent=0 -> first wenable 2 cycles after accept at addr 172800; 600 writes; last addr 172800+29*640+19=191379; done after 661 busy cycles.
- row=1 col=2 -> first addr 192040; row 1 of glyph starts at 192680; glyph_addr sequence char*30+0..29.
- Transparent=1 with all-zero glyph (space) -> zero wenable pulses; done still pulses at cycle 661.
- req_valid held high for two characters -> second accepted exactly 1 cycle after first done; no overlap of writes.
- reset asserted at 100th busy cycle -> next cycle busy=0, wenable=0, req_ready=1; no done.
- BOUNDS_CHECK_EN, row=7 col=0 -> err pulse, no writes; row=6 col=31 -> accepted, last addr 307199.
